// File: rtl/sd_resp_rx_pkg.sv
// Shared definitions for the SD command-line response receiver.
// - CRC7 polynomial and frame geometry constants.
// - Receiver FSM state type.
// - Default timeout and CRC start value used by the top-level parameters.
package sd_resp_rx_pkg;

  localparam logic [6:0] CRC7_POLY        = 7'h09;  // x^7 + x^3 + 1, x^7 implicit
  localparam int         RESP_LEN         = 48;
  localparam int         CRC_BITS         = 7;
  localparam int         NCR_MAX_DEFAULT  = 64;
  localparam logic [6:0] CRC_INIT_DEFAULT = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_SHIFT      = 3'd2,
    ST_CHECK      = 3'd3,
    ST_DONE       = 3'd4,
    ST_HOLD       = 3'd5
  } state_e;

endpackage

// File: rtl/sd_resp_rx_if.sv
// Signal bundle between the boot FSM (master) and the response receiver (slave).
// Inputs to the receiver:  Enable, cmd_i, no_crc_i.
// Outputs of the receiver: resp_idx, resp_arg, crc_rx, crc_ok, dir_err, end_err,
//                          timeout, done, and state_o (current FSM state, for debug).
// Handshake: Enable is a level. The receiver answers one armed period with at most
// one single-cycle done pulse; all result fields are valid from that cycle and stay
// stable until Enable is dropped and raised again (the re-arm clears the flags).
interface sd_resp_rx_if;
  import sd_resp_rx_pkg::*;

  logic        Enable;
  logic        cmd_i;
  logic        no_crc_i;
  logic [5:0]  resp_idx;
  logic [31:0] resp_arg;
  logic [6:0]  crc_rx;
  logic        crc_ok;
  logic        dir_err;
  logic        end_err;
  logic        timeout;
  logic        done;
  state_e      state_o;

  modport slave (
    input  Enable, cmd_i, no_crc_i,
    output resp_idx, resp_arg, crc_rx, crc_ok, dir_err, end_err, timeout, done, state_o
  );

  modport master (
    output Enable, cmd_i, no_crc_i,
    input  resp_idx, resp_arg, crc_rx, crc_ok, dir_err, end_err, timeout, done, state_o
  );

endinterface

// File: rtl/sd_resp_rx_crc7_serial.sv
// Bit-serial CRC7 (x^7+x^3+1), MSB-first. Shared with the command transmitter.
// Ports: clk_i, rst_ni (sync, active-low, loads INIT), bit_i (data bit),
//        en_i (advance one bit), clr_i (reload INIT, wins over en_i), crc_o.
module crc7_serial
  import sd_resp_rx_pkg::*;
#(
  parameter logic [6:0] INIT = CRC_INIT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bit_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[6] ^ bit_i;
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = INIT;
    end else if (en_i) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) crc_q <= INIT;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: waits for a start bit, shifts in one 48-bit frame,
// recomputes CRC7 over bits 47..8 and reports index, argument and error flags.
// Ports: CLK (rising edge), RST (sync, active-low), bus (sd_resp_rx_if.slave).
// Parameters: NCR_MAX (cycles allowed for the start bit), CRC_INIT (CRC start value).
module sd_resp_rx
  import sd_resp_rx_pkg::*;
#(
  parameter int         NCR_MAX  = NCR_MAX_DEFAULT,
  parameter logic [6:0] CRC_INIT = CRC_INIT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  sd_resp_rx_if.slave bus
);

  localparam int NCR_W = $clog2(NCR_MAX + 1);

  state_e           state_q, state_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [NCR_W-1:0] ncr_cnt_q, ncr_cnt_d;
  // Holds bits 46..0; the start bit is implied by being in a frame at all.
  logic [46:0]      shreg_q, shreg_d;
  logic [5:0]       resp_idx_q, resp_idx_d;
  logic [31:0]      resp_arg_q, resp_arg_d;
  logic [6:0]       crc_rx_q, crc_rx_d;
  logic             crc_ok_q, crc_ok_d;
  logic             dir_err_q, dir_err_d;
  logic             end_err_q, end_err_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             crc_en, crc_clr;
  logic [6:0]       crc_calc;

  crc7_serial #(.INIT(CRC_INIT)) u_crc (
    .clk_i  (CLK),
    .rst_ni (RST),
    .bit_i  (bus.cmd_i),
    .en_i   (crc_en),
    .clr_i  (crc_clr),
    .crc_o  (crc_calc)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ncr_cnt_d  = ncr_cnt_q;
    shreg_d    = shreg_q;
    resp_idx_d = resp_idx_q;
    resp_arg_d = resp_arg_q;
    crc_rx_d   = crc_rx_q;
    crc_ok_d   = crc_ok_q;
    dir_err_d  = dir_err_q;
    end_err_d  = end_err_q;
    timeout_d  = timeout_q;
    done_d     = 1'b0;
    crc_en     = 1'b0;
    crc_clr    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Enable) begin
          state_d   = ST_WAIT_START;
          bit_cnt_d = '0;
          ncr_cnt_d = '0;
          crc_clr   = 1'b1;
          crc_ok_d  = 1'b0;
          dir_err_d = 1'b0;
          end_err_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_WAIT_START: begin
        if (!bus.Enable) begin
          state_d = ST_IDLE;
        end else if (!bus.cmd_i) begin
          // Start bit (bit 47): with a zero bit the CRC step is a no-op, so a reload suffices.
          state_d   = ST_SHIFT;
          bit_cnt_d = 6'd46;
          shreg_d   = '0;
          crc_clr   = 1'b1;
        end else if (ncr_cnt_q == NCR_W'(NCR_MAX - 1)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          ncr_cnt_d = ncr_cnt_q + NCR_W'(1);
        end
      end
      ST_SHIFT: begin
        if (!bus.Enable) begin
          state_d = ST_IDLE;
        end else begin
          shreg_d   = {shreg_q[45:0], bus.cmd_i};
          bit_cnt_d = bit_cnt_q - 6'd1;
          crc_en    = (bit_cnt_q >= 6'd8);
          if (bit_cnt_q == 6'd0) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!bus.Enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          resp_idx_d = shreg_q[45:40];
          resp_arg_d = shreg_q[39:8];
          crc_rx_d   = shreg_q[7:1];
          crc_ok_d   = bus.no_crc_i | (crc_calc == shreg_q[7:1]);
          dir_err_d  = shreg_q[46];
          end_err_d  = ~shreg_q[0];
        end
      end
      ST_DONE: state_d = bus.Enable ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!bus.Enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      ncr_cnt_q  <= '0;
      shreg_q    <= '0;
      resp_idx_q <= '0;
      resp_arg_q <= '0;
      crc_rx_q   <= '0;
      crc_ok_q   <= 1'b0;
      dir_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ncr_cnt_q  <= ncr_cnt_d;
      shreg_q    <= shreg_d;
      resp_idx_q <= resp_idx_d;
      resp_arg_q <= resp_arg_d;
      crc_rx_q   <= crc_rx_d;
      crc_ok_q   <= crc_ok_d;
      dir_err_q  <= dir_err_d;
      end_err_q  <= end_err_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
    end
  end

  assign bus.resp_idx = resp_idx_q;
  assign bus.resp_arg = resp_arg_q;
  assign bus.crc_rx   = crc_rx_q;
  assign bus.crc_ok   = crc_ok_q;
  assign bus.dir_err  = dir_err_q;
  assign bus.end_err  = end_err_q;
  assign bus.timeout  = timeout_q;
  assign bus.done     = done_q;
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_sd_resp_rx.sv
// Bench for sd_resp_rx: directed vector table, hand-written corner sequences
// (reset, timeout, abort/re-arm) and randomized frames checked against a
// polynomial-division CRC7 reference model.
module tb_sd_resp_rx;
  import sd_resp_rx_pkg::*;

  localparam int NCR = 64;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   done_cnt;

  sd_resp_rx_if bus();

  sd_resp_rx #(.NCR_MAX(NCR), .CRC_INIT(7'h00)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    logic [46:0] g;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) begin
        g = 47'h89 << (i - 7);
        r = r ^ g;
      end
    end
    return r[6:0];
  endfunction

  // Expected result record: {idx, arg, crc_rx, crc_ok, dir_err, end_err, timeout}
  function automatic logic [48:0] ref_resp(input logic [47:0] f, input logic nc);
    logic ok;
    ok = nc || (ref_crc7(f[47:8]) == f[7:1]);
    return {f[45:40], f[39:8], f[7:1], ok, f[46], ~f[0], 1'b0};
  endfunction

  // ---------------- scoreboard ----------------
  logic [48:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_compare();
    logic [48:0] e;
    if (exp_q.size() == 0) begin
      check("sb_queue_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("resp_idx", 64'(bus.resp_idx), 64'(e[48:43]));
      check("resp_arg", 64'(bus.resp_arg), 64'(e[42:11]));
      check("crc_rx",   64'(bus.crc_rx),   64'(e[10:4]));
      check("crc_ok",   64'(bus.crc_ok),   64'(e[3]));
      check("dir_err",  64'(bus.dir_err),  64'(e[2]));
      check("end_err",  64'(bus.end_err),  64'(e[1]));
      check("timeout",  64'(bus.timeout),  64'(e[0]));
    end
  endtask

  // ---------------- driver tasks (start and end on a negedge) ----------------
  task automatic run_frame(input logic [47:0] f, input int idle, input logic nc);
    int n;
    int d0;
    d0 = done_cnt;
    bus.no_crc_i = nc;
    bus.Enable   = 1'b1;
    bus.cmd_i    = 1'b1;
    @(negedge clk);
    repeat (idle) @(negedge clk);
    for (int i = 47; i >= 0; i--) begin
      bus.cmd_i = f[i];
      @(negedge clk);
    end
    bus.cmd_i = 1'b1;
    n = 0;
    while (bus.done !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", 64'(n), 64'd1);
    sb_compare();
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);
    bus.Enable = 1'b0;
    @(negedge clk);
    check("done_pulse_count", 64'(done_cnt - d0), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [47:0] frame;
    logic        no_crc;
    int          idle;
    logic [48:0] exp;
  } vec_t;

  vec_t        vecs[5];
  logic [6:0]  t4_crc;
  logic [48:0] last_exp;

  initial begin
    int n;
    int d0;
    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    logic        r_dir, r_end, r_nc;
    logic [6:0]  r_crc, r_mask;
    logic [47:0] r_f;

    checks   = 0;
    failures = 0;
    done_cnt = 0;

    t4_crc = ref_crc7({2'b00, 6'h08, 32'h0000_01AA});
    vecs[0] = '{48'h40_0000_0000_95, 1'b0, 3, {6'h00, 32'h0000_0000, 7'h4A, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[1] = '{48'h51_0000_0000_55, 1'b0, 1, {6'h11, 32'h0000_0000, 7'h2A, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{48'h51_0000_1000_55, 1'b0, 0, {6'h11, 32'h0000_1000, 7'h2A, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[3] = '{{2'b00, 6'h08, 32'h0000_01AA, t4_crc, 1'b0}, 1'b0, 2,
                {6'h08, 32'h0000_01AA, t4_crc, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[4] = '{48'h3F_00FF_8000_FF, 1'b1, 4, {6'h3F, 32'h00FF_8000, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0}};

    // T1: reset dominates an armed Enable and a toggling CMD line
    rst          = 1'b0;
    bus.Enable   = 1'b1;
    bus.no_crc_i = 1'b0;
    bus.cmd_i    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.cmd_i = ~bus.cmd_i;
    end
    @(negedge clk);
    check("reset_outputs",
          64'({bus.resp_idx, bus.resp_arg, bus.crc_rx, bus.crc_ok, bus.dir_err,
               bus.end_err, bus.timeout, bus.done}), 64'd0);
    check("reset_state", 64'(bus.state_o), 64'(ST_IDLE));
    check("reset_no_done", 64'(done_cnt), 64'd0);
    bus.Enable = 1'b0;
    bus.cmd_i  = 1'b1;
    rst        = 1'b1;
    @(negedge clk);

    // T5: timeout with CMD held high
    d0 = done_cnt;
    bus.Enable = 1'b1;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 64'(n), 64'(NCR + 1));
    check("timeout_flag", 64'(bus.timeout), 64'd1);
    check("timeout_crc_ok", 64'(bus.crc_ok), 64'd0);
    @(negedge clk);
    check("timeout_done_one_cycle", 64'(bus.done), 64'd0);
    check("timeout_hold_flag", 64'(bus.timeout), 64'd1);
    bus.Enable = 1'b0;
    @(negedge clk);
    check("timeout_pulse_count", 64'(done_cnt - d0), 64'd1);

    // T2/T3/T4/R3 directed table
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].exp);
      last_exp = vecs[v].exp;
      run_frame(vecs[v].frame, vecs[v].idle, vecs[v].no_crc);
    end

    // T6: abort after bit 20, then re-arm and receive the T2 frame
    d0 = done_cnt;
    bus.no_crc_i = 1'b0;
    bus.Enable   = 1'b1;
    bus.cmd_i    = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    for (int i = 47; i >= 20; i--) begin
      bus.cmd_i = vecs[0].frame[i];
      @(negedge clk);
    end
    bus.Enable = 1'b0;
    bus.cmd_i  = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_state", 64'(bus.state_o), 64'(ST_IDLE));
    check("abort_keep_idx", 64'(bus.resp_idx), 64'(last_exp[48:43]));
    check("abort_keep_arg", 64'(bus.resp_arg), 64'(last_exp[42:11]));
    check("abort_flags_cleared", 64'({bus.crc_ok, bus.dir_err, bus.end_err, bus.timeout}), 64'd0);
    exp_q.push_back(vecs[0].exp);
    run_frame(vecs[0].frame, 3, 1'b0);

    // Randomized frames against the reference model
    for (int k = 0; k < 24; k++) begin
      r_idx = 6'($urandom_range(0, 63));
      r_arg = $urandom;
      r_dir = 1'($urandom_range(0, 1));
      r_end = ($urandom_range(0, 3) != 0);
      r_nc  = ($urandom_range(0, 4) == 0);
      r_crc = ref_crc7({1'b0, r_dir, r_idx, r_arg});
      if ($urandom_range(0, 3) == 0) begin
        r_mask = 7'h01 << $urandom_range(0, 6);
        r_crc  = r_crc ^ r_mask;
      end
      r_f = {1'b0, r_dir, r_idx, r_arg, r_crc, r_end};
      exp_q.push_back(ref_resp(r_f, r_nc));
      run_frame(r_f, $urandom_range(0, 5), r_nc);
    end

    check("sb_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
